// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and widths for the UART transmit arbiter and its round-robin
// picker.
//   arb_state_t : arbiter FSM states
//   GRANT_W     : width of a requester index (up to 8 requesters)
//   CNT_W       : per-grant byte counter width (9 bits so 256 compares exactly)
// -----------------------------------------------------------------------------
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, DRAIN} arb_state_t;
  localparam int GRANT_W = 3;
  localparam int CNT_W   = 9;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin search: returns the first set bit of
// i_req strictly after i_rr_ptr, wrapping around to index 0.
//   i_req     : request vector (N_REQ bits)
//   i_rr_ptr  : index of the most recently served requester
//   o_any     : at least one request is set
//   o_idx     : chosen requester index (meaningful when o_any=1)
// -----------------------------------------------------------------------------
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]   i_req,
  input  logic [GRANT_W-1:0] i_rr_ptr,
  output logic               o_any,
  output logic [GRANT_W-1:0] o_idx
);

  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    // Wrapped candidates (at or below the pointer): lowest index wins.
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req[j] && (GRANT_W'(j) <= i_rr_ptr)) o_idx = GRANT_W'(j);
    end
    // Candidates above the pointer take precedence over wrapped ones.
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req[j] && (GRANT_W'(j) > i_rr_ptr)) o_idx = GRANT_W'(j);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one async_transmitter among N_REQ byte-stream requesters using
// round-robin arbitration with packet lock. A grant is held until the owner
// flags its last byte or MAX_PKT bytes have been sent.
//   i_Clk, i_Rst_n : clock, asynchronous active-low reset
//   i_req_valid    : requester k has a byte ready
//   i_req_data     : byte of requester k in bits [8k+7:8k]
//   i_req_last     : presented byte ends requester k's packet
//   o_req_ready    : byte of requester k accepted this cycle (one-hot or zero)
//   o_tx_start     : one-cycle start pulse to the transmitter
//   o_tx_data      : byte to the transmitter, held until the next start
//   i_tx_busy      : transmitter busy
//   o_grant_id     : current owner, valid when o_active=1
//   o_active       : a grant is held
//
// Handshake: a byte moves from requester k when o_req_ready[k] and
// i_req_valid[k] are both high in the same cycle; the requester keeps valid,
// data and last stable until that cycle.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_PKT   = 256,
  parameter int BUSY_WAIT = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [8*N_REQ-1:0]   i_req_data,
  input  logic [N_REQ-1:0]     i_req_last,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic [GRANT_W-1:0]   o_grant_id,
  output logic                 o_active
);

  localparam int WAIT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  arb_state_t          r_state, w_state;
  logic [GRANT_W-1:0]  r_grant, w_grant;
  logic [GRANT_W-1:0]  r_rr_ptr, w_rr_ptr;
  logic                r_active, w_active;
  logic                r_tx_start, w_tx_start;
  logic [7:0]          r_tx_data, w_tx_data;
  logic [N_REQ-1:0]    r_ready, w_ready;
  logic                r_last, w_last;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [WAIT_W-1:0]   r_wait, w_wait;

  logic                w_any;
  logic [GRANT_W-1:0]  w_pick;
  logic                w_sel_valid;
  logic [7:0]          w_sel_data;
  logic                w_sel_last;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req    (i_req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_any    (w_any),
    .o_idx    (w_pick)
  );

  // Current owner's request signals.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = 8'h00;
    w_sel_last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_grant == GRANT_W'(k)) begin
        w_sel_valid = i_req_valid[k];
        w_sel_data  = i_req_data[8*k +: 8];
        w_sel_last  = i_req_last[k];
      end
    end
  end

  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_rr_ptr   = r_rr_ptr;
    w_active   = r_active;
    w_tx_start = 1'b0;
    w_tx_data  = r_tx_data;
    w_ready    = '0;
    w_last     = r_last;
    w_cnt      = r_cnt;
    w_wait     = r_wait;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant  = w_pick;
          w_active = 1'b1;
          w_cnt    = '0;
          w_state  = ISSUE;
        end
      end
      ISSUE: begin
        // A dropped valid keeps the grant: the packet stays atomic.
        if (w_sel_valid && !i_tx_busy) begin
          w_tx_start = 1'b1;
          w_tx_data  = w_sel_data;
          for (int k = 0; k < N_REQ; k++) w_ready[k] = (r_grant == GRANT_W'(k));
          w_last     = w_sel_last;
          w_cnt      = r_cnt + CNT_W'(1);
          w_wait     = '0;
          w_state    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // Give up waiting for busy after BUSY_WAIT cycles so a silent
        // transmitter cannot hang the arbiter.
        if (i_tx_busy || (r_wait == WAIT_W'(BUSY_WAIT - 1))) w_state = DRAIN;
        else w_wait = r_wait + WAIT_W'(1);
      end
      DRAIN: begin
        if (!i_tx_busy) begin
          if (r_last || (r_cnt == CNT_W'(MAX_PKT))) begin
            w_rr_ptr = r_grant;
            w_active = 1'b0;
            w_state  = IDLE;
          end else begin
            w_state = ISSUE;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= GRANT_W'(N_REQ - 1);
      r_active   <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_ready    <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_wait     <= '0;
    end else begin
      r_state    <= w_state;
      r_grant    <= w_grant;
      r_rr_ptr   <= w_rr_ptr;
      r_active   <= w_active;
      r_tx_start <= w_tx_start;
      r_tx_data  <= w_tx_data;
      r_ready    <= w_ready;
      r_last     <= w_last;
      r_cnt      <= w_cnt;
      r_wait     <= w_wait;
    end
  end

  assign o_req_ready = r_ready;
  assign o_tx_start  = r_tx_start;
  assign o_tx_data   = r_tx_data;
  assign o_grant_id  = r_grant;
  assign o_active    = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N    = 3;
  localparam int MAXP = 4;
  localparam int BW   = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic [2:0]     grant_id;
  logic           active;

  uart_tx_arbiter #(.N_REQ(N), .MAX_PKT(MAXP), .BUSY_WAIT(BW)) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy),
    .o_grant_id  (grant_id),
    .o_active    (active)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // requester queues: {last, data}
  logic [8:0]  rq0[$], rq1[$], rq2[$];
  logic [N-1:0] hold = '0;
  int          rise_cyc[N];
  logic [8:0]  f0, f1, f2;
  logic [N-1:0] nv;

  // scoreboard: {grant, data}
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int          obs_cyc[$];
  int          gap_q[$];
  int          last_fall_cyc = 0;
  int          frame_left = 0;
  logic [7:0]  prev_data = 8'h00;
  logic        prev_rst = 1'b0;

  // requester driver: pops after an accepted byte, presents the next one
  always @(negedge clk) begin
    if (req_valid[0] && req_ready[0] && rq0.size() > 0) void'(rq0.pop_front());
    if (req_valid[1] && req_ready[1] && rq1.size() > 0) void'(rq1.pop_front());
    if (req_valid[2] && req_ready[2] && rq2.size() > 0) void'(rq2.pop_front());
    f0 = (rq0.size() > 0) ? rq0[0] : 9'h000;
    f1 = (rq1.size() > 0) ? rq1[0] : 9'h000;
    f2 = (rq2.size() > 0) ? rq2[0] : 9'h000;
    nv = {(rq2.size() > 0) && !hold[2], (rq1.size() > 0) && !hold[1], (rq0.size() > 0) && !hold[0]};
    for (int k = 0; k < N; k++) if (nv[k] && !req_valid[k]) rise_cyc[k] = cyc;
    req_valid = nv;
    req_data  = {f2[7:0], f1[7:0], f0[7:0]};
    req_last  = {f2[8], f1[8], f0[8]};
  end

  // monitor + transmitter model (busy for 8..14 cycles after each start)
  always @(negedge clk) begin
    if (tx_start) begin
      n_cmp++;
      if (tx_busy) begin
        n_fail++; $display("FAIL start_while_busy: busy=%b required 0 (cyc %0d)", tx_busy, cyc);
      end
      n_cmp++;
      if (req_ready !== (N'(1) << grant_id)) begin
        n_fail++; $display("FAIL ready_align: ready=%b required %b", req_ready, N'(1) << grant_id);
      end
      n_cmp++;
      if (active !== 1'b1) begin
        n_fail++; $display("FAIL start_active: active=%b required 1", active);
      end
      obs_q.push_back({grant_id, tx_data});
      obs_cyc.push_back(cyc);
      gap_q.push_back(cyc - last_fall_cyc);
    end else begin
      n_cmp++;
      if (req_ready !== '0) begin
        n_fail++; $display("FAIL ready_no_start: ready=%b required 000", req_ready);
      end
    end
    if (tx_busy && rst_n && prev_rst) begin
      n_cmp++;
      if (tx_data !== prev_data) begin
        n_fail++; $display("FAIL data_stable: data=%h required %h while busy", tx_data, prev_data);
      end
    end
    prev_data = tx_data;
    prev_rst  = rst_n;
    if (frame_left > 0) begin
      frame_left--;
      if (frame_left == 0) begin
        tx_busy = 1'b0;
        last_fall_cyc = cyc;
      end
    end else if (tx_start) begin
      tx_busy = 1'b1;
      frame_left = int'($urandom_range(8, 14));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_req(input int k, input logic last, input logic [7:0] d);
    case (k)
      0: rq0.push_back({last, d});
      1: rq1.push_back({last, d});
      default: rq2.push_back({last, d});
    endcase
  endtask

  task automatic clear_obs();
    obs_q.delete(); obs_cyc.delete(); gap_q.delete(); exp_q.delete();
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int t = 0;
    while (obs_q.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic apply_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    rq0.delete(); rq1.delete(); rq2.delete();
    hold = '0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++; if (tx_start !== 1'b0)  begin n_fail++; $display("FAIL rst_start: got %b required 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_data: got %h required 00", tx_data); end
    n_cmp++; if (req_ready !== '0)   begin n_fail++; $display("FAIL rst_ready: got %b required 000", req_ready); end
    n_cmp++; if (grant_id !== 3'd0)  begin n_fail++; $display("FAIL rst_grant: got %0d required 0", grant_id); end
    n_cmp++; if (active !== 1'b0)    begin n_fail++; $display("FAIL rst_active: got %b required 0", active); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    bit ok;
    int t;
    clear_obs();
    push_req(0, 1'b0, 8'h4F);
    push_req(0, 1'b1, 8'h4B);
    exp_q.push_back({3'd0, 8'h4F});
    exp_q.push_back({3'd0, 8'h4B});
    wait_obs(2, 200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_timeout: starts=%0d required 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_seq[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (obs_cyc[0] - rise_cyc[0] !== 2) begin n_fail++; $display("FAIL first_latency: got %0d required 2", obs_cyc[0] - rise_cyc[0]); end
    n_cmp++;
    if (gap_q[1] < 1 || gap_q[1] > 2) begin n_fail++; $display("FAIL b2b_gap: got %0d required 1..2", gap_q[1]); end
    t = 0;
    while (active && t < 100) begin tick(1); t++; end
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL single_release: active=%b required 0", active); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL release_early: busy=%b required 0 at release", tx_busy); end
    // rr pointer now 0: requester 1 must win over requester 0
    clear_obs();
    push_req(0, 1'b1, 8'h78);
    push_req(1, 1'b1, 8'h79);
    exp_q.push_back({3'd1, 8'h79});
    exp_q.push_back({3'd0, 8'h78});
    wait_obs(2, 200, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ptr0_seq[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    tick(20);
  endtask

  task automatic test_contention();
    bit ok;
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      clear_obs();
      for (int k = 0; k < N; k++) begin
        push_req(k, 1'b1, 8'hA0 + 8'(k) + 8'(rep * 16));
        exp_q.push_back({3'(k), 8'hA0 + 8'(k) + 8'(rep * 16)});
      end
      wait_obs(3, 300, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL contention_timeout: starts=%0d required 3", obs_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL contention_seq[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
      end
      tick(20);
    end
  endtask

  task automatic test_packet_lock();
    bit ok;
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      push_req(1, i == 2, 8'h10 + 8'(i));
      exp_q.push_back({3'd1, 8'h10 + 8'(i)});
    end
    exp_q.push_back({3'd0, 8'h55});
    wait_obs(1, 100, ok);
    push_req(0, 1'b1, 8'h55);
    wait_obs(4, 300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL lock_timeout: starts=%0d required 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lock_seq[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    tick(20);
  endtask

  task automatic test_valid_gap();
    bit ok;
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      push_req(0, i == 2, 8'h20 + 8'(i));
      exp_q.push_back({3'd0, 8'h20 + 8'(i)});
    end
    exp_q.push_back({3'd1, 8'h66});
    wait_obs(1, 100, ok);
    hold[0] = 1'b1;
    push_req(1, 1'b1, 8'h66);
    tick(50);
    n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL gap_no_start: starts=%0d required 1", obs_q.size()); end
    n_cmp++; if (active !== 1'b1 || grant_id !== 3'd0) begin
      n_fail++; $display("FAIL gap_grant_held: active=%b grant=%0d required 1/0", active, grant_id);
    end
    hold[0] = 1'b0;
    wait_obs(4, 300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL gap_timeout: starts=%0d required 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gap_seq[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    tick(20);
  endtask

  task automatic test_max_pkt();
    bit ok;
    apply_reset();
    clear_obs();
    for (int i = 0; i < 10; i++) push_req(0, 1'b0, 8'h30 + 8'(i));
    push_req(2, 1'b1, 8'h77);
    for (int i = 0; i < 4; i++) exp_q.push_back({3'd0, 8'h30 + 8'(i)});
    exp_q.push_back({3'd2, 8'h77});
    for (int i = 4; i < 10; i++) exp_q.push_back({3'd0, 8'h30 + 8'(i)});
    wait_obs(11, 600, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL maxpkt_timeout: starts=%0d required 11", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL maxpkt_seq[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    tick(30);
    // 2 bytes into the third grant with no last: the grant must still be held
    n_cmp++; if (active !== 1'b1 || grant_id !== 3'd0) begin
      n_fail++; $display("FAIL maxpkt_hold: active=%b grant=%0d required 1/0", active, grant_id);
    end
    apply_reset();
    tick(20);
  endtask

  // Reference model: round-robin over requesters with pending bytes; each
  // grant drains bytes until a last flag or MAXP bytes.
  logic [8:0] mbuf[N][64];
  int mhead[N], mtail[N];
  int m_ptr;

  task automatic test_random();
    bit ok;
    int total, g, cnt, np, len;
    logic [7:0] d;
    logic lst;
    apply_reset();
    m_ptr = N - 1;
    for (int round = 0; round < 2; round++) begin
      clear_obs();
      total = 0;
      for (int k = 0; k < N; k++) begin
        mhead[k] = 0; mtail[k] = 0;
        np = int'($urandom_range(1, 3));
        for (int p = 0; p < np; p++) begin
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            lst = (b == len - 1);
            push_req(k, lst, d);
            mbuf[k][mtail[k]] = {lst, d};
            mtail[k]++;
            total++;
          end
        end
      end
      while (exp_q.size() < total) begin
        g = -1;
        for (int i = 1; i <= N; i++) begin
          if (g < 0 && mhead[(m_ptr + i) % N] < mtail[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
        cnt = 0;
        do begin
          lst = mbuf[g][mhead[g]][8];
          exp_q.push_back({3'(g), mbuf[g][mhead[g]][7:0]});
          mhead[g]++;
          cnt++;
        end while (!lst && cnt < MAXP);
        m_ptr = g;
      end
      wait_obs(total, 40 * total + 100, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: starts=%0d required %0d", obs_q.size(), total); end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_seq[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
      end
      tick(30);
    end
  endtask

  task automatic test_reset_drain();
    bit ok;
    int t, n0;
    clear_obs();
    push_req(0, 1'b0, 8'h41);
    push_req(0, 1'b1, 8'h42);
    wait_obs(1, 100, ok);
    tick(3);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rd_start: got %b required 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rd_data: got %h required 00", tx_data); end
    n_cmp++; if (req_ready !== '0)  begin n_fail++; $display("FAIL rd_ready: got %b required 000", req_ready); end
    n_cmp++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL rd_grant: got %0d required 0", grant_id); end
    n_cmp++; if (active !== 1'b0)   begin n_fail++; $display("FAIL rd_active: got %b required 0", active); end
    tick(2);
    rst_n = 1'b1;
    n0 = obs_q.size();
    t = 0;
    while (tx_busy && t < 100) begin tick(1); t++; end
    n_cmp++; if (obs_q.size() !== n0) begin n_fail++; $display("FAIL rd_no_start_busy: starts=%0d required %0d", obs_q.size(), n0); end
    wait_obs(n0 + 1, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd_timeout: starts=%0d required %0d", obs_q.size(), n0 + 1); end
    n_cmp++; if (obs_q[n0] !== {3'd0, 8'h42}) begin n_fail++; $display("FAIL rd_byte: got %h required %h", obs_q[n0], {3'd0, 8'h42}); end
    n_cmp++; if (obs_cyc[n0] - last_fall_cyc !== 1) begin
      n_fail++; $display("FAIL rd_latency: got %0d required 1", obs_cyc[n0] - last_fall_cyc);
    end
    tick(30);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_packet_lock();
    test_valid_gap();
    test_max_pkt();
    test_random();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
